fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Hardware control-unit timing generator that drives the CPU `control_bus`, replacing hand-driven bench stimulus.
- Produces the T0–T4 instruction-fetch micro-sequence:
  - PC onto the address bus.
  - Memory onto the data bus.
  - Two bytes written into IR0/IR1, with PC increments.
- Hands off to an execute stage through a req/ack handshake.
- Sits between the decoder/executor and the CPU datapath's bus-ID decoders.

Parameters:
- PC_AMID, 0, address-master ID of the program counter.
- MEM_MID, 4, data-bus master ID of main memory.
- IR0_SID, 0, data-bus slave ID of instruction register byte 0.
- IR1_SID, 1, data-bus slave ID of instruction register byte 1.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the falling edge, giving the datapath half a cycle of setup before its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin fetching when idle.
- run  input  1  1 = continuous fetch/execute loop; 0 = single instruction.
- halt  input  1  stop at the next instruction boundary.
- exec_ack  input  1  execute stage finished the current instruction.
- control_bus  output  33  packed as follows; all bits registered.
  - [0] AMID_EN
  - [1] SID_EN
  - [2] MID_EN
  - [3] PC_INR
  - [5:4] AMID
  - [10:6] SID
  - [15:11] MID
  - [20:16] alu_opcode, always 0 from this block
  - [32:21] tied 0
- busy  output  1  high in any state except IDLE.
- fetch_done  output  1  one-cycle pulse during T4.
- exec_req  output  1  high throughout EXEC.
- instr_count  output  CNT_W  number of completed fetches.

Behaviour:
- States: IDLE, T0, T1, T2, T3, T4, EXEC. Moore machine; outputs are registered decode of the state entered at each negedge.
- Reset (reset=0, asynchronous, any time including mid-fetch):
  - state=IDLE.
  - control_bus=0, busy=0, fetch_done=0, exec_req=0, instr_count=0.
- IDLE:
  - All control_bus fields 0.
  - start=1 at a negedge → T0.
- T0: AMID=PC_AMID, AMID_EN=1, MID=MEM_MID, MID_EN=1.
- T1: T0 values held, plus SID=IR0_SID, SID_EN=1, PC_INR=1.
- T2: SID_EN=0, PC_INR=0. AMID_EN/MID_EN held 1.
- T3: SID=IR1_SID, SID_EN=1, PC_INR=1.
- T4:
  - AMID_EN=MID_EN=SID_EN=PC_INR=0. ID fields keep their last values (don't-care).
  - fetch_done=1.
  - instr_count increments on entry to T4, wrapping from all-ones to 0.
- Transitions T0→T1→T2→T3→T4→EXEC are unconditional, one clock each. start is ignored outside IDLE.
- EXEC:
  - exec_req=1, all enables 0.
  - Stays in EXEC while exec_ack=0.
  - exec_ack=1 at a negedge:
    - → T0 if run=1 and halt=0;
    - → IDLE otherwise.
- halt is sampled only at EXEC exit. Asserting halt mid-fetch never truncates a fetch.
- PC_INR is high for exactly one clock in T1 and one in T3, so PC advances by exactly 2 per fetch.
- Latency: start sampled at negedge n → T0 outputs valid after negedge n; fetch_done high after negedge n+4; exec_req first high after negedge n+5.
- exec_ack=1 while not in EXEC is ignored.

Optional Feature:
- FETCH_SEQ_WAIT_EN defined:
  - Adds input mem_ready (1 bit) and states W0, W2.
  - T0→W0 and T2→W2 instead of going straight to T1/T3.
  - W0/W2 hold T0/T2 outputs, with SID_EN=0 and PC_INR=0, until mem_ready=1 at a negedge, then → T1/T3.
  - With mem_ready tied 1, each wait state lasts exactly one clock.
- Undefined: no mem_ready port, no wait states; timing exactly as above.

Test Plan:
- Reset low at t=0, released at 10 ns, start held 0 → control_bus=0, busy=0, instr_count=0 indefinitely.
- start=1 one cycle, run=0 → control_bus sequence:
  - T0 = 0x02005
  - T1 = 0x0200F
  - T2 = 0x02005
  - T3 = 0x0204F
  - T4 = PC_INR and all enables 0
  - then EXEC with exec_req=1; exec_ack pulse → IDLE, instr_count=1; PC in CPU advanced by 2.
- run=1, exec_ack returned 2 cycles after each exec_req, 10 instructions → 10 fetch_done pulses, instr_count=10, no gap between EXEC exit and T0.
- run=1, halt asserted during T2 → current fetch completes, EXEC entered, exec_ack → IDLE, busy=0.
- reset pulsed low during T3 → all outputs 0 immediately (before next edge); start afterwards restarts cleanly at T0.
- FETCH_SEQ_WAIT_EN with mem_ready low 3 cycles in W0 → PC_INR stays 0 and MID_EN stays 1 throughout; T1 follows mem_ready=1; total PC increments = 2.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch timing generator: walks T0..T4, hands off to execute via exec_req/exec_ack.
// Optional macro FETCH_SEQ_WAIT_EN adds mem_ready and the W0/W2 memory wait states.
module fetch_sequencer #(
   parameter int unsigned PC_AMID = 0,
   parameter int unsigned MEM_MID = 4,
   parameter int unsigned IR0_SID = 0,
   parameter int unsigned IR1_SID = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             run,
   input  logic             halt,
   input  logic             exec_ack,
`ifdef FETCH_SEQ_WAIT_EN
   input  logic             mem_ready,
`endif
   output logic [32:0]      control_bus,
   output logic             busy,
   output logic             fetch_done,
   output logic             exec_req,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state_dbg
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T2   = 4'd3,
      T3   = 4'd4,
      T4   = 4'd5,
      EXEC = 4'd6,
      W0   = 4'd7,
      W2   = 4'd8
   } state_t;

   localparam logic [1:0] PC_AMID_V = PC_AMID[1:0];
   localparam logic [4:0] MEM_MID_V = MEM_MID[4:0];
   localparam logic [4:0] IR0_SID_V = IR0_SID[4:0];
   localparam logic [4:0] IR1_SID_V = IR1_SID[4:0];

   state_t     state;
   state_t     next_state;
   logic       amid_en;
   logic       sid_en;
   logic       mid_en;
   logic       pc_inr;
   logic [1:0] amid;
   logic [4:0] sid;
   logic [4:0] mid;

   // alu_opcode and the upper bits are never driven by this block.
   assign control_bus = {12'd0, 5'd0, mid, sid, amid, pc_inr, mid_en, sid_en, amid_en};
   assign state_dbg   = state;

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = T0;
`ifdef FETCH_SEQ_WAIT_EN
         T0:   next_state = W0;
         W0:   if (mem_ready) next_state = T1;
         T2:   next_state = W2;
         W2:   if (mem_ready) next_state = T3;
`else
         T0:   next_state = T1;
         T2:   next_state = T3;
`endif
         T1:   next_state = T2;
         T3:   next_state = T4;
         T4:   next_state = EXEC;
         EXEC: if (exec_ack) next_state = (run && !halt) ? T0 : IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are decoded from the state being entered so they are registered with it.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         amid_en     <= 1'b0;
         sid_en      <= 1'b0;
         mid_en      <= 1'b0;
         pc_inr      <= 1'b0;
         amid        <= '0;
         sid         <= '0;
         mid         <= '0;
         busy        <= 1'b0;
         fetch_done  <= 1'b0;
         exec_req    <= 1'b0;
         instr_count <= '0;
      end else begin
         state      <= next_state;
         busy       <= (next_state != IDLE);
         fetch_done <= (next_state == T4);
         exec_req   <= (next_state == EXEC);
         if (next_state == T4) instr_count <= instr_count + 1'b1;
         case (next_state)
            T0, W0: begin
               amid_en <= 1'b1;
               mid_en  <= 1'b1;
               sid_en  <= 1'b0;
               pc_inr  <= 1'b0;
               amid    <= PC_AMID_V;
               mid     <= MEM_MID_V;
               sid     <= IR0_SID_V;
            end
            T1: begin
               amid_en <= 1'b1;
               mid_en  <= 1'b1;
               sid_en  <= 1'b1;
               pc_inr  <= 1'b1;
               amid    <= PC_AMID_V;
               mid     <= MEM_MID_V;
               sid     <= IR0_SID_V;
            end
            T2, W2: begin
               amid_en <= 1'b1;
               mid_en  <= 1'b1;
               sid_en  <= 1'b0;
               pc_inr  <= 1'b0;
            end
            T3: begin
               amid_en <= 1'b1;
               mid_en  <= 1'b1;
               sid_en  <= 1'b1;
               pc_inr  <= 1'b1;
               sid     <= IR1_SID_V;
            end
            T4, EXEC: begin
               amid_en <= 1'b0;
               mid_en  <= 1'b0;
               sid_en  <= 1'b0;
               pc_inr  <= 1'b0;
            end
            default: begin
               amid_en <= 1'b0;
               mid_en  <= 1'b0;
               sid_en  <= 1'b0;
               pc_inr  <= 1'b0;
               amid    <= '0;
               sid     <= '0;
               mid     <= '0;
            end
         endcase
      end
   end

endmodule
